// File: rtl/cdb_wb_arbiter.sv
// cdb_wb_arbiter
//   Writeback arbiter between the execution lanes and the Common Data Bus.
//   Each lane pushes completed results into a small FIFO. A round-robin scan
//   that starts at rr_ptr drains up to NUM_CDB_PORTS FIFO heads per cycle.
//
// Ports
//   clk, rst        core clock, synchronous active-high reset
//   flush           drops every buffered result and rewinds rr_ptr
//   lane_v/robid/data/rd   per-lane result push (flat, lane i at slice i)
//   lane_full       per-lane buffer-full flag (registered) for issue backpressure
//   cdb_v/robid/data/rd/lane   per-port broadcast (flat, port k at slice k)
//   ovf_err         sticky: a push arrived while its lane was full

// Per-lane result FIFO. full is a flop loaded with the post-edge occupancy,
// so it never anticipates a pop happening in the current cycle.
module cdb_wb_lane_buf #(
   parameter int DEPTH = 2,
   parameter int EW    = 43
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic [EW-1:0] push_entry,
   input  logic          pop,
   output logic [EW-1:0] head,
   output logic          nonempty,
   output logic          full
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count, count_nxt;
   logic          push_ok, pop_ok;

   assign nonempty = (count != '0);
   assign head     = mem[rd_ptr];
   assign push_ok  = push & ~full & ~flush & ~rst;
   assign pop_ok   = pop & nonempty & ~flush & ~rst;

   always_comb begin
      count_nxt = count;
      if (push_ok && !pop_ok)
         count_nxt = count + 1'b1;
      else if (!push_ok && pop_ok)
         count_nxt = count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         full  <= (count_nxt == CW'(DEPTH));
      end
   end

   // Storage is not reset; stale contents are masked by cdb_v at the top.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_entry;
   end
endmodule

module cdb_wb_arbiter #(
   parameter int NUM_LANES      = 4,
   parameter int NUM_CDB_PORTS  = 2,
   parameter int LANE_BUF_DEPTH = 2,
   parameter int ROB_SIZE_CLOG  = 6,
   parameter int DATA_LEN       = 32,
   localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                flush,
   input  logic [NUM_LANES-1:0]                lane_v,
   input  logic [NUM_LANES*ROB_SIZE_CLOG-1:0]  lane_robid,
   input  logic [NUM_LANES*DATA_LEN-1:0]       lane_data,
   input  logic [NUM_LANES*5-1:0]              lane_rd,
   output logic [NUM_LANES-1:0]                lane_full,
   output logic [NUM_CDB_PORTS-1:0]            cdb_v,
   output logic [NUM_CDB_PORTS*ROB_SIZE_CLOG-1:0] cdb_robid,
   output logic [NUM_CDB_PORTS*DATA_LEN-1:0]   cdb_data,
   output logic [NUM_CDB_PORTS*5-1:0]          cdb_rd,
   output logic [NUM_CDB_PORTS*LW-1:0]         cdb_lane,
   output logic                                ovf_err
);
   localparam int RW = ROB_SIZE_CLOG;
   localparam int EW = RW + DATA_LEN + 5;

   logic [EW-1:0]            head [NUM_LANES];
   logic [NUM_LANES-1:0]     nonempty, grant;
   logic [LW-1:0]            rr_ptr, rr_nxt, last_lane, lane;
   logic [NUM_CDB_PORTS-1:0] port_v;
   logic [LW-1:0]            port_lane [NUM_CDB_PORTS];
   int                       scan, n_found, nxt_i;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      cdb_wb_lane_buf #(
         .DEPTH (LANE_BUF_DEPTH),
         .EW    (EW)
      ) u_buf (
         .clk        (clk),
         .rst        (rst),
         .flush      (flush),
         .push       (lane_v[i]),
         .push_entry ({lane_robid[i*RW +: RW], lane_data[i*DATA_LEN +: DATA_LEN],
                       lane_rd[i*5 +: 5]}),
         .pop        (grant[i]),
         .head       (head[i]),
         .nonempty   (nonempty[i]),
         .full       (lane_full[i])
      );
   end

   // Round-robin scan: walk lanes from rr_ptr upward with wrap; the k-th
   // non-empty lane met is granted port k.
   always_comb begin
      grant     = '0;
      port_v    = '0;
      last_lane = '0;
      lane      = '0;
      scan      = 0;
      n_found   = 0;
      for (int k = 0; k < NUM_CDB_PORTS; k++) port_lane[k] = '0;
      for (int j = 0; j < NUM_LANES; j++) begin
         scan = int'(rr_ptr) + j;
         if (scan >= NUM_LANES) scan = scan - NUM_LANES;
         lane = LW'(scan);
         if (nonempty[lane] && n_found < NUM_CDB_PORTS) begin
            grant[lane] = 1'b1;
            for (int k = 0; k < NUM_CDB_PORTS; k++) begin
               if (k == n_found) begin
                  port_v[k]    = 1'b1;
                  port_lane[k] = lane;
               end
            end
            last_lane = lane;
            n_found   = n_found + 1;
         end
      end
   end

   always_comb begin
      nxt_i = int'(last_lane) + 1;
      if (nxt_i >= NUM_LANES) nxt_i = 0;
      rr_nxt = LW'(nxt_i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr  <= '0;
         ovf_err <= 1'b0;
      end else if (flush) begin
         rr_ptr <= '0;
      end else begin
         if (|grant) rr_ptr <= rr_nxt;
         if (|(lane_v & lane_full)) ovf_err <= 1'b1;
      end
   end

   // Buffers ignore pops under flush/rst, so the broadcast is masked too;
   // otherwise a head would be shown without being consumed.
   for (genvar k = 0; k < NUM_CDB_PORTS; k++) begin : g_port
      logic [EW-1:0] sel;
      assign sel      = head[port_lane[k]];
      assign cdb_v[k] = port_v[k] & ~flush & ~rst;
      assign cdb_robid[k*RW +: RW]             = cdb_v[k] ? sel[EW-1 -: RW] : '0;
      assign cdb_data[k*DATA_LEN +: DATA_LEN]  = cdb_v[k] ? sel[5 +: DATA_LEN] : '0;
      assign cdb_rd[k*5 +: 5]                  = cdb_v[k] ? sel[4:0] : '0;
      assign cdb_lane[k*LW +: LW]              = cdb_v[k] ? port_lane[k] : '0;
   end
endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Bench for cdb_wb_arbiter (4 lanes, 2 ports, depth 2): directed vector
// table, hand-written flush/reset sequences, then random traffic against a
// queue-based reference model.
module tb_cdb_wb_arbiter;
   logic        clk = 1'b0;
   logic        rst, flush;
   logic [3:0]  lane_v;
   logic [23:0] lane_robid;
   logic [127:0] lane_data;
   logic [19:0] lane_rd;
   logic [3:0]  lane_full;
   logic [1:0]  cdb_v;
   logic [11:0] cdb_robid;
   logic [63:0] cdb_data;
   logic [9:0]  cdb_rd;
   logic [3:0]  cdb_lane;
   logic        ovf_err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cdb_wb_arbiter #(
      .NUM_LANES(4), .NUM_CDB_PORTS(2), .LANE_BUF_DEPTH(2),
      .ROB_SIZE_CLOG(6), .DATA_LEN(32)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .lane_v(lane_v), .lane_robid(lane_robid), .lane_data(lane_data),
      .lane_rd(lane_rd), .lane_full(lane_full),
      .cdb_v(cdb_v), .cdb_robid(cdb_robid), .cdb_data(cdb_data),
      .cdb_rd(cdb_rd), .cdb_lane(cdb_lane), .ovf_err(ovf_err)
   );

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] fdata(input logic [5:0] r);
      return 32'hCAFE_0000 | {26'h0, r};
   endfunction
   function automatic logic [4:0] frd(input logic [5:0] r);
      return r[4:0] ^ 5'h15;
   endfunction

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_lane(input int i, input logic v, input logic [5:0] r,
                           input logic [31:0] d, input logic [4:0] rdv);
      lane_v[i] = v;
      lane_robid[i*6 +: 6] = r;
      lane_data[i*32 +: 32] = d;
      lane_rd[i*5 +: 5] = rdv;
   endtask

   task automatic drive(input logic r, input logic f, input logic [3:0] v,
                        input logic [3:0][5:0] rob);
      rst = r;
      flush = f;
      for (int i = 0; i < 4; i++) set_lane(i, v[i], rob[i], fdata(rob[i]), frd(rob[i]));
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_port(input string nm, input int k, input logic ev,
                           input logic [5:0] er, input logic [1:0] el);
      cmp($sformatf("%s.p%0d.v", nm, k), cdb_v[k], ev);
      cmp($sformatf("%s.p%0d.robid", nm, k), cdb_robid[k*6 +: 6], ev ? er : 6'd0);
      cmp($sformatf("%s.p%0d.data", nm, k), cdb_data[k*32 +: 32], ev ? fdata(er) : 32'd0);
      cmp($sformatf("%s.p%0d.rd", nm, k), cdb_rd[k*5 +: 5], ev ? frd(er) : 5'd0);
      cmp($sformatf("%s.p%0d.lane", nm, k), cdb_lane[k*2 +: 2], ev ? el : 2'd0);
   endtask

   task automatic chk_all(input string nm, input logic [1:0] ev,
                          input logic [5:0] er0, input logic [1:0] el0,
                          input logic [5:0] er1, input logic [1:0] el1,
                          input logic [3:0] efull, input logic eovf);
      chk_port(nm, 0, ev[0], er0, el0);
      chk_port(nm, 1, ev[1], er1, el1);
      cmp({nm, ".lane_full"}, lane_full, efull);
      cmp({nm, ".ovf_err"}, ovf_err, eovf);
   endtask

   // Directed vectors: inputs for one cycle and the outputs expected in it.
   typedef struct packed {
      logic rst; logic flush; logic [3:0] v; logic [3:0][5:0] rob;
      logic [1:0] ev; logic [5:0] er0; logic [1:0] el0;
      logic [5:0] er1; logic [1:0] el1; logic [3:0] efull; logic eovf;
   } vec_t;
   vec_t tbl [12];

   // Reference model: one queue per lane, rotating start index.
   typedef struct packed { logic [5:0] rob; logic [31:0] data; logic [4:0] rd; } ent_t;
   ent_t mq [4][$];
   int   mrr;
   bit   movf;
   ent_t st [4];

   task automatic mstep(input logic r, input logic f, input logic [3:0] v);
      ent_t pe [2];
      int   pl [2];
      int   np, last;
      logic [3:0] efull;
      rst = r;
      flush = f;
      for (int i = 0; i < 4; i++) set_lane(i, v[i], st[i].rob, st[i].data, st[i].rd);
      np = 0;
      last = 0;
      pe[0] = '0; pe[1] = '0; pl[0] = 0; pl[1] = 0;
      for (int i = 0; i < 4; i++) efull[i] = (mq[i].size() == 2);
      if (!r && !f) begin
         for (int j = 0; j < 4; j++) begin
            int l;
            l = (mrr + j) % 4;
            if (mq[l].size() > 0 && np < 2) begin
               pe[np] = mq[l][0];
               pl[np] = l;
               np++;
               last = l;
            end
         end
      end
      #3;
      for (int k = 0; k < 2; k++) begin
         logic ev;
         ev = (k < np);
         cmp($sformatf("model.p%0d.v", k), cdb_v[k], ev);
         cmp($sformatf("model.p%0d.robid", k), cdb_robid[k*6 +: 6], ev ? pe[k].rob : 6'd0);
         cmp($sformatf("model.p%0d.data", k), cdb_data[k*32 +: 32], ev ? pe[k].data : 32'd0);
         cmp($sformatf("model.p%0d.rd", k), cdb_rd[k*5 +: 5], ev ? pe[k].rd : 5'd0);
         cmp($sformatf("model.p%0d.lane", k), cdb_lane[k*2 +: 2], ev ? 2'(pl[k]) : 2'd0);
      end
      cmp("model.lane_full", lane_full, efull);
      cmp("model.ovf_err", ovf_err, movf);
      if (r) begin
         for (int i = 0; i < 4; i++) mq[i].delete();
         mrr = 0;
         movf = 0;
      end else if (f) begin
         for (int i = 0; i < 4; i++) mq[i].delete();
         mrr = 0;
      end else begin
         for (int k = 0; k < np; k++) void'(mq[pl[k]].pop_front());
         if (np > 0) mrr = (last + 1) % 4;
         for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
               if (efull[i]) movf = 1;
               else mq[i].push_back(st[i]);
            end
         end
      end
      next();
   endtask

   initial begin
      logic [3:0] rv;
      int seq;
      rst = 1'b1; flush = 1'b0; lane_v = '0;
      lane_robid = '0; lane_data = '0; lane_rd = '0;
      repeat (2) @(posedge clk);
      #1;

      // Single result with explicit fields.
      rst = 1'b0;
      set_lane(0, 1'b1, 6'd5, 32'hDEADBEEF, 5'd3);
      #3;
      cmp("single.c1.v", cdb_v, 2'b00);
      next();
      lane_v = '0;
      #3;
      cmp("single.c2.v", cdb_v, 2'b01);
      cmp("single.c2.robid", cdb_robid[5:0], 6'd5);
      cmp("single.c2.data", cdb_data[31:0], 32'hDEADBEEF);
      cmp("single.c2.rd", cdb_rd[4:0], 5'd3);
      cmp("single.c2.lane", cdb_lane[1:0], 2'd0);
      next();
      #3;
      cmp("single.c3.v", cdb_v, 2'b00);
      next();
      rst = 1'b1;
      next();

      // Contention, rr restart, backpressure and overflow.
      tbl[0]  = '{1'b0, 1'b0, 4'b0000, {6'd0, 6'd0, 6'd0, 6'd0},     2'b00, 6'd0, 2'd0, 6'd0, 2'd0, 4'b0000, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 4'b1111, {6'd13, 6'd12, 6'd11, 6'd10}, 2'b00, 6'd0, 2'd0, 6'd0, 2'd0, 4'b0000, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 4'b0000, {6'd0, 6'd0, 6'd0, 6'd0},     2'b11, 6'd10, 2'd0, 6'd11, 2'd1, 4'b0000, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 4'b0000, {6'd0, 6'd0, 6'd0, 6'd0},     2'b11, 6'd12, 2'd2, 6'd13, 2'd3, 4'b0000, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 4'b0000, {6'd0, 6'd0, 6'd0, 6'd0},     2'b00, 6'd0, 2'd0, 6'd0, 2'd0, 4'b0000, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 4'b1001, {6'd21, 6'd0, 6'd0, 6'd20},   2'b00, 6'd0, 2'd0, 6'd0, 2'd0, 4'b0000, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 4'b0000, {6'd0, 6'd0, 6'd0, 6'd0},     2'b11, 6'd20, 2'd0, 6'd21, 2'd3, 4'b0000, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 4'b0111, {6'd0, 6'd32, 6'd31, 6'd30},  2'b00, 6'd0, 2'd0, 6'd0, 2'd0, 4'b0000, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 4'b0111, {6'd0, 6'd35, 6'd34, 6'd33},  2'b11, 6'd30, 2'd0, 6'd31, 2'd1, 4'b0000, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 4'b0100, {6'd0, 6'd36, 6'd0, 6'd0},    2'b11, 6'd32, 2'd2, 6'd33, 2'd0, 4'b0100, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 4'b0000, {6'd0, 6'd0, 6'd0, 6'd0},     2'b11, 6'd34, 2'd1, 6'd35, 2'd2, 4'b0000, 1'b1};
      tbl[11] = '{1'b0, 1'b0, 4'b0000, {6'd0, 6'd0, 6'd0, 6'd0},     2'b00, 6'd0, 2'd0, 6'd0, 2'd0, 4'b0000, 1'b1};
      for (int r = 0; r < 12; r++) begin
         drive(tbl[r].rst, tbl[r].flush, tbl[r].v, tbl[r].rob);
         #3;
         chk_all($sformatf("tbl%0d", r), tbl[r].ev, tbl[r].er0, tbl[r].el0,
                 tbl[r].er1, tbl[r].el1, tbl[r].efull, tbl[r].eovf);
         next();
      end

      // Flush with pending heads and a push in the flush cycle (rr_ptr=3 now).
      drive(0, 0, 4'b0111, {6'd0, 6'd42, 6'd41, 6'd40});
      #3; chk_all("flush.c1", 2'b00, 0, 0, 0, 0, 4'b0000, 1'b1); next();
      drive(0, 1, 4'b0010, {6'd0, 6'd0, 6'd43, 6'd0});
      #3; chk_all("flush.c2", 2'b00, 0, 0, 0, 0, 4'b0000, 1'b1); next();
      drive(0, 0, 4'b0000, '0);
      #3; chk_all("flush.c3", 2'b00, 0, 0, 0, 0, 4'b0000, 1'b1); next();
      drive(0, 0, 4'b1100, {6'd45, 6'd44, 6'd0, 6'd0});
      #3; chk_all("flush.c4", 2'b00, 0, 0, 0, 0, 4'b0000, 1'b1); next();
      drive(0, 0, 4'b0000, '0);
      #3; chk_all("flush.c5", 2'b11, 6'd44, 2'd2, 6'd45, 2'd3, 4'b0000, 1'b1); next();
      #3; chk_all("flush.c6", 2'b00, 0, 0, 0, 0, 4'b0000, 1'b1); next();

      // Reset mid-stream with rr_ptr=2 and two full lanes.
      drive(0, 0, 4'b1111, {6'd53, 6'd52, 6'd51, 6'd50});
      #3; chk_all("rst.c1", 2'b00, 0, 0, 0, 0, 4'b0000, 1'b1); next();
      drive(0, 0, 4'b1111, {6'd57, 6'd56, 6'd55, 6'd54});
      #3; chk_all("rst.c2", 2'b11, 6'd50, 2'd0, 6'd51, 2'd1, 4'b0000, 1'b1); next();
      drive(1, 0, 4'b0000, '0);
      next();
      drive(0, 0, 4'b1010, {6'd61, 6'd0, 6'd60, 6'd0});
      #3; chk_all("rst.c4", 2'b00, 0, 0, 0, 0, 4'b0000, 1'b0); next();
      drive(0, 0, 4'b0000, '0);
      #3; chk_all("rst.c5", 2'b11, 6'd60, 2'd1, 6'd61, 2'd3, 4'b0000, 1'b0); next();
      #3; chk_all("rst.c6", 2'b00, 0, 0, 0, 0, 4'b0000, 1'b0); next();

      // Model-checked phase: fairness between lanes 0 and 3, then random.
      for (int i = 0; i < 4; i++) st[i] = '0;
      mstep(1, 0, 4'b0000);
      seq = 0;
      for (int c = 0; c < 20; c++) begin
         st[0] = '{rob: 6'(seq), data: $urandom, rd: 5'($urandom)};
         st[3] = '{rob: 6'(seq + 32), data: $urandom, rd: 5'($urandom)};
         seq++;
         mstep(0, 0, 4'b1001);
      end
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 4; i++) begin
            st[i] = '{rob: 6'($urandom), data: $urandom, rd: 5'($urandom)};
            if (mq[i].size() == 2) rv[i] = ($urandom_range(0, 15) == 0);
            else rv[i] = ($urandom_range(0, 1) == 1);
         end
         mstep($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0, rv);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
